// File: rtl/x1_loader_pkg.sv
// x1_loader_pkg
//   Shared types and constants for the Sharp X1 ioctl download loader.
//   - sel_e    : download target (IPL ROM, CGROM, main RAM image)
//   - state_e  : loader sequencing states
//   - entry_t  : buffered write {sel, addr, data}, 26 bits packed
//   - target_limit() : exclusive byte-address limit for an ioctl_index;
//                      unknown indices map to 0 so no address is accepted.
package x1_loader_pkg;

  typedef enum logic [1:0] {
    SEL_IPL   = 2'd0,
    SEL_CGROM = 2'd1,
    SEL_MRAM  = 2'd2
  } sel_e;

  localparam logic [24:0] LIM_IPL   = 25'h000_8000;
  localparam logic [24:0] LIM_CGROM = 25'h000_1000;
  localparam logic [24:0] LIM_MRAM  = 25'h001_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_HOLD
  } state_e;

  typedef struct packed {
    sel_e        sel;
    logic [15:0] addr;
    logic [7:0]  data;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

  function automatic logic [24:0] target_limit(input logic [7:0] idx);
    logic [24:0] lim;
    case (idx)
      8'd0:    lim = LIM_IPL;
      8'd1:    lim = LIM_CGROM;
      8'd2:    lim = LIM_MRAM;
      default: lim = '0;
    endcase
    return lim;
  endfunction

endpackage

// File: rtl/x1_loader_fifo.sv
// x1_loader_fifo
//   Synchronous single-clock FIFO buffering loader writes.
//   Ports:
//     i_clk, i_reset_n : clock, synchronous active-low reset (empties FIFO)
//     i_push, i_data   : write request and data; a push to a full FIFO is
//                        taken only when a pop happens in the same cycle
//     i_pop            : remove head entry (ignored when empty)
//     o_data           : current head entry (valid when !o_empty)
//     o_full, o_empty  : status
//     o_fill           : number of stored entries
module x1_loader_fifo #(
  parameter int unsigned WIDTH = 26,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_fill
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_fill;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_fill == (AW+1)'(DEPTH));
  assign o_empty = (r_fill == '0);
  assign o_fill  = r_fill;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

endmodule

// File: rtl/x1_ioctl_loader.sv
// x1_ioctl_loader
//   Download-side loader for the Sharp X1 core. Decodes ioctl_index into a
//   target, buffers accepted bytes in a FIFO and drains them to the memory
//   write port with a req/ack handshake. Holds the core in reset while a
//   download is in progress and for HOLD_CYCLES after the buffer drains.
//   Ports:
//     clk_sys, reset_n        : clock, synchronous active-low reset
//     ioctl_download/index/wr/addr/dout : HPS download stream
//     ioctl_wait              : host stall request (registered)
//     mem_req/ack/sel/addr/data : memory write handshake
//     core_reset_n            : core reset, low while loading
//     load_done               : one-cycle pulse at end of load sequence
//     load_count, load_sum    : accepted byte count and modulo-256 sum
//     overflow                : sticky, byte dropped on a full FIFO
module x1_ioctl_loader
  import x1_loader_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [1:0]  mem_sel,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        core_reset_n,
  output logic        load_done,
  output logic [16:0] load_count,
  output logic [7:0]  load_sum,
  output logic        overflow
);

  localparam int unsigned FW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_e             r_state;
  logic [7:0]         r_index;
  logic [HW-1:0]      r_hold_cnt;
  logic               r_mem_req;
  logic [1:0]         r_mem_sel;
  logic [15:0]        r_mem_addr;
  logic [7:0]         r_mem_data;
  logic               r_ioctl_wait;
  logic               r_core_reset_n;
  logic               r_load_done;
  logic [16:0]        r_load_count;
  logic [7:0]         r_load_sum;
  logic               r_overflow;

  entry_t             w_push_entry;
  entry_t             w_head;
  logic [ENTRY_W-1:0] w_head_bits;
  logic               w_full;
  logic               w_empty;
  logic [FW-1:0]      w_fill;
  logic [FW-1:0]      w_fill_next;
  logic [24:0]        w_limit;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic               w_drop;

  // Unknown indices yield a zero limit, so they never accept a byte.
  assign w_limit  = target_limit(r_index);
  assign w_accept = (r_state == ST_LOAD) && ioctl_wr && (ioctl_addr < w_limit);
  assign w_pop    = r_mem_req && mem_ack;
  assign w_push   = w_accept && (!w_full || w_pop);
  assign w_drop   = w_accept && w_full && !w_pop;

  assign w_push_entry = '{sel: sel_e'(r_index[1:0]), addr: ioctl_addr[15:0], data: ioctl_dout};
  assign w_head       = entry_t'(w_head_bits);

  always_comb begin
    w_fill_next = w_fill;
    if (w_push && !w_pop) begin
      w_fill_next = w_fill + 1'b1;
    end else if (!w_push && w_pop) begin
      w_fill_next = w_fill - 1'b1;
    end
  end

  x1_loader_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (clk_sys),
    .i_reset_n (reset_n),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_data    (w_push_entry),
    .o_data    (w_head_bits),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_fill    (w_fill)
  );

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_index        <= '0;
      r_hold_cnt     <= '0;
      r_mem_req      <= 1'b0;
      r_mem_sel      <= '0;
      r_mem_addr     <= '0;
      r_mem_data     <= '0;
      r_ioctl_wait   <= 1'b0;
      r_core_reset_n <= 1'b0;
      r_load_done    <= 1'b0;
      r_load_count   <= '0;
      r_load_sum     <= '0;
      r_overflow     <= 1'b0;
    end else begin
      r_load_done    <= 1'b0;
      // Released one edge after the FSM has settled in IDLE.
      r_core_reset_n <= (r_state == ST_IDLE) && !ioctl_download;
      r_ioctl_wait   <= (w_fill_next >= FW'(FIFO_DEPTH - 1));

      // The presented entry stays in the FIFO until acked; the output
      // register is reloaded from the new head on the cycle after a pop.
      if (w_pop) begin
        r_mem_req <= 1'b0;
      end else if (!r_mem_req && !w_empty) begin
        r_mem_req  <= 1'b1;
        r_mem_sel  <= w_head.sel;
        r_mem_addr <= w_head.addr;
        r_mem_data <= w_head.data;
      end

      if (w_push) begin
        r_load_count <= r_load_count + 17'd1;
        r_load_sum   <= r_load_sum + ioctl_dout;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end

      case (r_state)
        ST_LOAD: begin
          if (!ioctl_download) begin
            r_state <= ST_DRAIN;
          end
        end
        default: begin
          if (ioctl_download) begin
            r_state      <= ST_LOAD;
            r_index      <= ioctl_index;
            r_load_count <= '0;
            r_load_sum   <= '0;
            r_overflow   <= 1'b0;
            r_hold_cnt   <= '0;
          end else if (r_state == ST_DRAIN) begin
            // Leave once the last outstanding entry is acked this cycle.
            if (w_fill_next == '0) begin
              r_state    <= ST_HOLD;
              r_hold_cnt <= '0;
            end
          end else if (r_state == ST_HOLD) begin
            if (r_hold_cnt == HW'(HOLD_CYCLES - 1)) begin
              r_state     <= ST_IDLE;
              r_load_done <= 1'b1;
            end else begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign ioctl_wait   = r_ioctl_wait;
  assign mem_req      = r_mem_req;
  assign mem_sel      = r_mem_sel;
  assign mem_addr     = r_mem_addr;
  assign mem_data     = r_mem_data;
  assign core_reset_n = r_core_reset_n;
  assign load_done    = r_load_done;
  assign load_count   = r_load_count;
  assign load_sum     = r_load_sum;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_x1_ioctl_loader.sv
// Self-checking bench for x1_ioctl_loader: directed scenarios with random
// data/addresses/ack patterns, checked against a queue-based model.
module tb_x1_ioctl_loader;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned HOLD  = 16;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        mem_req;
  logic        mem_ack;
  logic [1:0]  mem_sel;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        core_reset_n;
  logic        load_done;
  logic [16:0] load_count;
  logic [7:0]  load_sum;
  logic        overflow;

  always #5 clk_sys = ~clk_sys;

  x1_ioctl_loader #(
    .FIFO_DEPTH  (DEPTH),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .mem_req        (mem_req),
    .mem_ack        (mem_ack),
    .mem_sel        (mem_sel),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .core_reset_n   (core_reset_n),
    .load_done      (load_done),
    .load_count     (load_count),
    .load_sum       (load_sum),
    .overflow       (overflow)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: q holds accepted-but-unacknowledged writes in order.
  logic [25:0] q[$];
  bit          m_load;
  logic [7:0]  m_idx;
  int unsigned m_count;
  logic [7:0]  m_sum;
  bit          m_ovf;
  bit          m_wait;
  int          last_ack_cyc;
  int          n_pops;
  bit          req_seen;
  int          dcyc;

  function automatic int unsigned limit_of(input logic [7:0] idx);
    case (idx)
      8'd0:    return 32768;
      8'd1:    return 4096;
      8'd2:    return 65536;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit pop;
    int unsigned pre;
    if (!reset_n) begin
      q.delete();
      m_load  = 0;
      m_count = 0;
      m_sum   = 0;
      m_ovf   = 0;
      m_wait  = 0;
    end else begin
      pre = q.size();
      pop = mem_req && mem_ack;
      if (mem_req) req_seen = 1;
      if (pre == 0) chk("req_when_empty", {31'd0, mem_req}, 32'd0);
      if (pop && pre > 0) begin
        chk("pop_entry", {6'd0, mem_sel, mem_addr, mem_data}, {6'd0, q[0]});
        void'(q.pop_front());
        n_pops++;
        last_ack_cyc = cyc;
      end
      if (m_load && ioctl_wr && (ioctl_addr < limit_of(m_idx))) begin
        if (pre < DEPTH || pop) begin
          q.push_back({m_idx[1:0], ioctl_addr[15:0], ioctl_dout});
          m_count++;
          m_sum += ioctl_dout;
        end else begin
          m_ovf = 1;
        end
      end
      m_wait = (q.size() >= DEPTH - 1);
    end
    @(posedge clk_sys);
    #1;
    cyc++;
    chk("ioctl_wait", {31'd0, ioctl_wait}, {31'd0, m_wait});
    chk("overflow",   {31'd0, overflow},   {31'd0, m_ovf});
    chk("load_count", {15'd0, load_count}, m_count);
    chk("load_sum",   {24'd0, load_sum},   {24'd0, m_sum});
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    m_count  = 0;
    m_sum    = 0;
    m_ovf    = 0;
    n_pops   = 0;
    req_seen = 0;
    tick();
    m_load = 1;
    m_idx  = idx;
    chk("core_reset_low_on_start", {31'd0, core_reset_n}, 32'd0);
  endtask

  task automatic wr(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    tick();
    m_load = 0;
  endtask

  task automatic wait_done(input int budget, input bit rand_ack);
    bit seen;
    seen = 0;
    dcyc = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      if (rand_ack) mem_ack = 1'($urandom_range(0, 1));
      tick();
      if (load_done) begin
        seen = 1;
        dcyc = cyc;
      end
    end
    chk("load_done_seen", {31'd0, seen}, 32'd1);
    chk("core_reset_at_done", {31'd0, core_reset_n}, 32'd0);
    mem_ack = 1'b1;
    tick();
    chk("load_done_one_cycle", {31'd0, load_done}, 32'd0);
    chk("core_reset_release", {31'd0, core_reset_n}, 32'd1);
  endtask

  initial begin
    int sent;
    int guard;
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = '0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    mem_ack        = 1'b0;
    m_load = 0; m_idx = '0; m_count = 0; m_sum = '0; m_ovf = 0; m_wait = 0;
    last_ack_cyc = 0; n_pops = 0; req_seen = 0; dcyc = 0;

    // Reset state
    tick();
    tick();
    chk("rst_mem_req",      {31'd0, mem_req},      32'd0);
    chk("rst_load_done",    {31'd0, load_done},    32'd0);
    chk("rst_core_reset_n", {31'd0, core_reset_n}, 32'd0);
    chk("rst_mem_sel",      {30'd0, mem_sel},      32'd0);
    chk("rst_mem_addr",     {16'd0, mem_addr},     32'd0);
    chk("rst_mem_data",     {24'd0, mem_data},     32'd0);
    reset_n = 1'b1;
    tick();
    chk("core_reset_n_after_rst", {31'd0, core_reset_n}, 32'd1);

    // 1: IPL, three bytes, ack tied high
    mem_ack = 1'b1;
    start_dl(8'd0);
    wr(25'd0, 8'h11);
    chk("latency_not_yet", {31'd0, mem_req}, 32'd0);
    wr(25'd1, 8'h22);
    chk("latency_req", {31'd0, mem_req}, 32'd1);
    chk("latency_addr", {16'd0, mem_addr}, 32'd0);
    wr(25'd2, 8'h33);
    end_dl();
    wait_done(200, 1'b0);
    chk("t1_pops", n_pops, 3);
    chk("t1_count", {15'd0, load_count}, 32'd3);
    chk("t1_sum", {24'd0, load_sum}, 32'h66);
    chk("t1_done_latency", dcyc - last_ack_cyc, HOLD + 1);

    // 2: ack low, host honours wait, 8 bytes to MRAM
    mem_ack = 1'b0;
    start_dl(8'd2);
    for (int i = 0; i < 3; i++) wr(25'($urandom_range(0, 16'hFFFF)), 8'($urandom_range(0, 255)));
    chk("t2_wait_after_3", {31'd0, ioctl_wait}, 32'd1);
    for (int i = 0; i < 3; i++) tick();
    chk("t2_no_overflow_stall", {31'd0, overflow}, 32'd0);
    sent  = 3;
    guard = 0;
    while (sent < 8 && guard < 300) begin
      mem_ack = 1'($urandom_range(0, 1));
      if (!ioctl_wait) begin
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'($urandom_range(0, 16'hFFFF));
        ioctl_dout = 8'($urandom_range(0, 255));
        sent++;
      end else begin
        ioctl_wr = 1'b0;
      end
      tick();
      guard++;
    end
    ioctl_wr = 1'b0;
    chk("t2_sent", sent, 8);
    end_dl();
    wait_done(400, 1'b1);
    chk("t2_pops", n_pops, 8);
    chk("t2_count", {15'd0, load_count}, 32'd8);
    chk("t2_overflow", {31'd0, overflow}, 32'd0);

    // 3: host ignores wait, 5 writes with ack low
    mem_ack = 1'b0;
    start_dl(8'd0);
    for (int i = 0; i < 5; i++) wr(25'($urandom_range(0, 16'h7FFF)), 8'($urandom_range(0, 255)));
    chk("t3_overflow", {31'd0, overflow}, 32'd1);
    chk("t3_count", {15'd0, load_count}, 32'd4);
    end_dl();
    mem_ack = 1'b1;
    wait_done(200, 1'b0);
    chk("t3_pops", n_pops, 4);

    // 4: CGROM boundary
    start_dl(8'd1);
    wr(25'h0FFF, 8'($urandom_range(0, 255)));
    wr(25'h1000, 8'($urandom_range(0, 255)));
    end_dl();
    wait_done(200, 1'b0);
    chk("t4_pops", n_pops, 1);
    chk("t4_count", {15'd0, load_count}, 32'd1);

    // 5: invalid index
    start_dl(8'($urandom_range(3, 255)));
    for (int i = 0; i < 10; i++) wr(25'($urandom_range(0, 16'hFFFF)), 8'($urandom_range(0, 255)));
    end_dl();
    wait_done(200, 1'b0);
    chk("t5_no_req", {31'd0, req_seen}, 32'd0);
    chk("t5_count", {15'd0, load_count}, 32'd0);

    // 6: reset mid-load with two bytes buffered
    mem_ack = 1'b0;
    start_dl(8'd2);
    wr(25'($urandom_range(0, 16'hFFFF)), 8'($urandom_range(0, 255)));
    wr(25'($urandom_range(0, 16'hFFFF)), 8'($urandom_range(0, 255)));
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    tick();
    m_load = 0;
    chk("t6_rst_req", {31'd0, mem_req}, 32'd0);
    chk("t6_rst_core", {31'd0, core_reset_n}, 32'd0);
    reset_n = 1'b1;
    mem_ack = 1'b1;
    tick();
    chk("t6_empty_req", {31'd0, mem_req}, 32'd0);
    tick();
    chk("t6_empty_req2", {31'd0, mem_req}, 32'd0);
    start_dl(8'd0);
    chk("t6_count_start", {15'd0, load_count}, 32'd0);
    wr(25'($urandom_range(0, 16'h7FFF)), 8'($urandom_range(0, 255)));
    wr(25'($urandom_range(0, 16'h7FFF)), 8'($urandom_range(0, 255)));
    end_dl();
    wait_done(200, 1'b0);
    chk("t6_count", {15'd0, load_count}, 32'd2);
    chk("t6_pops", n_pops, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
